// File: rtl/instruction_fetch_if.sv
// ----------------------------------------------------------------------------
// instruction_fetch_if
// Groups the fetch stage's instruction-memory port, redirect input and IF/ID
// handshake into one bundle.
//   imem_pc        fetch byte address presented to instruction memory
//   imem_instr     instruction word returned combinationally for imem_pc
//   branch_taken   single-cycle redirect request from execute
//   branch_target  redirect byte address, valid with branch_taken
//   id_ready       decode can accept the IF/ID entry this cycle
//   id_valid       IF/ID entry holds a valid instruction
//   id_instr       registered instruction word
//   id_pc          byte address id_instr was fetched from
//   trap           sticky misaligned / out-of-range fetch flag
// master: the fetch unit.  slave: memory, execute and decode around it.
// ----------------------------------------------------------------------------
interface instruction_fetch_if;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        trap;

    modport master (
        output imem_pc,
        input  imem_instr,
        input  branch_taken,
        input  branch_target,
        input  id_ready,
        output id_valid,
        output id_instr,
        output id_pc,
        output trap
    );

    modport slave (
        input  imem_pc,
        output imem_instr,
        output branch_taken,
        output branch_target,
        output id_ready,
        input  id_valid,
        input  id_instr,
        input  id_pc,
        input  trap
    );
endinterface

// File: rtl/instruction_fetch.sv
// ----------------------------------------------------------------------------
// instruction_fetch
// Single-issue fetch stage. A pc register addresses instruction memory and
// the returned word is captured into an IF/ID register with a valid/ready
// handshake. Execute may redirect the pc. Misaligned or out-of-range
// fetch/redirect addresses send the unit into a sticky TRAP state that only
// reset clears.
// Ports:
//   clk    single clock, rising edge
//   reset  asynchronous, active-low reset
//   bus    instruction_fetch_if.master (memory, redirect, IF/ID handshake)
// Parameters:
//   RESET_PC    first fetch address after reset
//   IMEM_BYTES  instruction memory size in bytes; legal pc 0..IMEM_BYTES-4
// ----------------------------------------------------------------------------
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 256
) (
    input  logic                       clk,
    input  logic                       reset,
    instruction_fetch_if.master        bus
);

    localparam logic [31:0] PC_MAX = 32'(IMEM_BYTES - 32'd4);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRAP = 2'd2
    } state_t;

    // A fetch address is usable only when word aligned and inside memory.
    function automatic logic addr_legal(input logic [31:0] addr);
        return (addr[1:0] == 2'b00) && (addr <= PC_MAX);
    endfunction

    state_t      state_r;
    state_t      state_n;
    logic [31:0] pc_r;
    logic [31:0] pc_n;
    logic        id_valid_r;
    logic        id_valid_n;
    logic [31:0] id_instr_r;
    logic [31:0] id_instr_n;
    logic [31:0] id_pc_r;
    logic [31:0] id_pc_n;
    logic        trap_r;
    logic        trap_n;
    logic        slot_free_s;
    logic        handshake_s;

    assign slot_free_s = !id_valid_r || bus.id_ready;
    assign handshake_s = id_valid_r && bus.id_ready;

    assign bus.imem_pc  = pc_r;
    assign bus.id_valid = id_valid_r;
    assign bus.id_instr = id_instr_r;
    assign bus.id_pc    = id_pc_r;
    assign bus.trap     = trap_r;

    // State and pipeline registers; reset discards any pending entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            pc_r       <= RESET_PC;
            id_valid_r <= 1'b0;
            id_instr_r <= 32'h0000_0000;
            id_pc_r    <= 32'h0000_0000;
            trap_r     <= 1'b0;
        end else begin
            state_r    <= state_n;
            pc_r       <= pc_n;
            id_valid_r <= id_valid_n;
            id_instr_r <= id_instr_n;
            id_pc_r    <= id_pc_n;
            trap_r     <= trap_n;
        end
    end

    // Next-state and datapath control: redirect beats fault check beats fetch.
    always_comb begin
        state_n    = state_r;
        pc_n       = pc_r;
        id_valid_n = id_valid_r;
        id_instr_n = id_instr_r;
        id_pc_n    = id_pc_r;
        trap_n     = trap_r;

        case (state_r)
            // One settle cycle after reset; redirects are not accepted yet.
            ST_IDLE: begin
                state_n = ST_RUN;
            end

            ST_RUN: begin
                if (bus.branch_taken) begin
                    // Flush the entry even if decode is stalled.
                    id_valid_n = 1'b0;
                    if (addr_legal(bus.branch_target)) begin
                        pc_n = bus.branch_target;
                    end else begin
                        // pc keeps its old value so the fault is observable.
                        state_n = ST_TRAP;
                        trap_n  = 1'b1;
                    end
                end else if (!addr_legal(pc_r)) begin
                    // No capture; an already captured entry may still drain.
                    state_n    = ST_TRAP;
                    trap_n     = 1'b1;
                    id_valid_n = id_valid_r && !bus.id_ready;
                end else if (slot_free_s) begin
                    id_instr_n = bus.imem_instr;
                    id_pc_n    = pc_r;
                    id_valid_n = 1'b1;
                    pc_n       = pc_r + 32'd4;
                end else begin
                    // Decode stall: hold everything.
                    pc_n       = pc_r;
                    id_valid_n = id_valid_r;
                end
            end

            ST_TRAP: begin
                trap_n = 1'b1;
                if (handshake_s) begin
                    id_valid_n = 1'b0;
                end else begin
                    id_valid_n = id_valid_r;
                end
            end

            // Unreachable encoding: fail safe into the trap state.
            default: begin
                state_n    = ST_TRAP;
                trap_n     = 1'b1;
                id_valid_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch
// Directed scenarios plus randomized redirect/stall/reset traffic against a
// transaction-level reference of the fetch stage.
// ----------------------------------------------------------------------------
module tb_instruction_fetch;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          IMEM_BYTES = 256;

    logic clk;
    logic reset;
    instruction_fetch_if bus();

    instruction_fetch #(
        .RESET_PC   (RESET_PC),
        .IMEM_BYTES (IMEM_BYTES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock: period 10, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [7:0] mem [0:IMEM_BYTES-1];

    // Little-endian word read; addresses outside memory return a marker.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr <= 32'(IMEM_BYTES - 4)) begin
            return {mem[addr + 32'd3], mem[addr + 32'd2], mem[addr + 32'd1], mem[addr]};
        end
        return 32'hDEAD_BEEF;
    endfunction

    assign bus.imem_instr = mem_word(bus.imem_pc);

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic        m_trap;
    logic        m_started;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit model_legal(input logic [31:0] a);
        longint unsigned la;
        la = longint'(a);
        return ((la % 4) == 0) && (la + 4 <= longint'(IMEM_BYTES));
    endfunction

    task automatic model_reset();
        m_pc      = RESET_PC;
        m_valid   = 1'b0;
        m_instr   = 32'h0;
        m_ipc     = 32'h0;
        m_trap    = 1'b0;
        m_started = 1'b0;
    endtask

    // One clock of the fetch stage as seen from outside.
    task automatic model_step(input logic rdy, input logic br, input logic [31:0] tgt);
        bit consumed;
        consumed = m_valid && rdy;
        if (!m_started) begin
            m_started = 1'b1;
        end else if (m_trap) begin
            if (consumed) m_valid = 1'b0;
        end else if (br) begin
            m_valid = 1'b0;
            if (model_legal(tgt)) m_pc = tgt;
            else m_trap = 1'b1;
        end else if (!model_legal(m_pc)) begin
            m_trap = 1'b1;
            if (consumed) m_valid = 1'b0;
        end else if (!m_valid || rdy) begin
            m_ipc   = m_pc;
            m_instr = mem_word(m_pc);
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
        end
    endtask

    task automatic compare_all(input string tag);
        check_value({tag, ".id_valid"}, {31'd0, bus.id_valid}, {31'd0, m_valid});
        check_value({tag, ".id_instr"}, bus.id_instr, m_instr);
        check_value({tag, ".id_pc"},    bus.id_pc,    m_ipc);
        check_value({tag, ".trap"},     {31'd0, bus.trap}, {31'd0, m_trap});
        check_value({tag, ".imem_pc"},  bus.imem_pc,  m_pc);
    endtask

    // Called at a negedge: drive, clock, update model, compare at next negedge.
    task automatic cycle(input logic rdy, input logic br, input logic [31:0] tgt, input string tag);
        bus.id_ready      = rdy;
        bus.branch_taken  = br;
        bus.branch_target = tgt;
        @(posedge clk);
        model_step(rdy, br, tgt);
        @(negedge clk);
        compare_all(tag);
    endtask

    // Called at a negedge: assert reset between edges, check, release off-edge.
    task automatic apply_reset();
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_value("rst.id_valid", {31'd0, bus.id_valid}, 32'd0);
        check_value("rst.id_instr", bus.id_instr, 32'h0);
        check_value("rst.id_pc",    bus.id_pc,    32'h0);
        check_value("rst.trap",     {31'd0, bus.trap}, 32'd0);
        check_value("rst.imem_pc",  bus.imem_pc,  RESET_PC);
        @(negedge clk);
        compare_all("rst_hold");
        #3 reset = 1'b1;
    endtask

    initial begin
        logic [31:0] tgt;
        logic        br;
        logic        rdy;

        reset             = 1'b0;
        bus.id_ready      = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 32'h0;
        for (int i = 0; i < IMEM_BYTES; i++) mem[i] = 8'($urandom);
        model_reset();

        @(negedge clk);
        apply_reset();

        // Sequential stream: idle cycle, then pc 0,4,8 one per cycle
        cycle(1'b1, 1'b0, 32'h0, "idle");
        check_value("idle.no_capture", {31'd0, bus.id_valid}, 32'd0);
        cycle(1'b1, 1'b0, 32'h0, "seq");
        check_value("seq.first_pc", bus.id_pc, 32'd0);
        check_value("seq.first_instr", bus.id_instr, mem_word(32'd0));
        cycle(1'b1, 1'b0, 32'h0, "seq");
        cycle(1'b1, 1'b0, 32'h0, "seq");
        check_value("seq.pc8", bus.id_pc, 32'd8);

        // Stall three cycles holding entry 8 with pc at 12
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 32'h0, "stall");
            check_value("stall.id_pc", bus.id_pc, 32'd8);
            check_value("stall.imem_pc", bus.imem_pc, 32'd12);
        end
        cycle(1'b1, 1'b0, 32'h0, "resume");
        check_value("resume.id_pc", bus.id_pc, 32'd12);

        // Branch during a stall flushes and redirects
        cycle(1'b0, 1'b1, 32'd16, "branch");
        check_value("branch.flush", {31'd0, bus.id_valid}, 32'd0);
        check_value("branch.imem_pc", bus.imem_pc, 32'd16);
        cycle(1'b1, 1'b0, 32'h0, "branch_fetch");
        check_value("branch.id_pc", bus.id_pc, 32'd16);

        // Misaligned target traps; later branches are ignored
        cycle(1'b1, 1'b1, 32'd6, "mis");
        check_value("mis.trap", {31'd0, bus.trap}, 32'd1);
        check_value("mis.imem_pc", bus.imem_pc, 32'd20);
        cycle(1'b1, 1'b1, 32'd16, "trap_ign");
        check_value("trap_ign.imem_pc", bus.imem_pc, 32'd20);

        // Out-of-range target traps
        @(negedge clk);
        apply_reset();
        cycle(1'b1, 1'b0, 32'h0, "oor");
        cycle(1'b1, 1'b0, 32'h0, "oor");
        cycle(1'b1, 1'b1, 32'd256, "oor_br");
        check_value("oor.trap", {31'd0, bus.trap}, 32'd1);
        check_value("oor.imem_pc", bus.imem_pc, 32'd4);

        // Run off the end of memory: 252 delivered, then trap
        @(negedge clk);
        apply_reset();
        for (int i = 0; i < 65; i++) cycle(1'b1, 1'b0, 32'h0, "end");
        check_value("end.last_pc", bus.id_pc, 32'd252);
        check_value("end.imem_pc", bus.imem_pc, 32'd256);
        cycle(1'b1, 1'b0, 32'h0, "end_trap");
        check_value("end.trap", {31'd0, bus.trap}, 32'd1);
        check_value("end.no_valid", {31'd0, bus.id_valid}, 32'd0);
        cycle(1'b1, 1'b0, 32'h0, "end_after");

        // Mid-stream reset, including during a stall, then refetch
        @(negedge clk);
        apply_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h0, "mid");
        cycle(1'b0, 1'b0, 32'h0, "mid_stall");
        apply_reset();
        cycle(1'b1, 1'b0, 32'h0, "refetch");
        cycle(1'b1, 1'b0, 32'h0, "refetch");
        check_value("refetch.id_pc", bus.id_pc, RESET_PC);

        // Randomized traffic with occasional resets
        for (int ep = 0; ep < 10; ep++) begin
            apply_reset();
            for (int c = 0; c < 250; c++) begin
                rdy = ($urandom_range(0, 3) != 0);
                br  = ($urandom_range(0, 11) == 0);
                if ($urandom_range(0, 5) == 0) tgt = 32'($urandom_range(0, 300));
                else tgt = 32'($urandom_range(0, 63)) * 32'd4;
                cycle(rdy, br, tgt, "rand");
                if ($urandom_range(0, 199) == 0) apply_reset();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter IMEM_BYTES, default 256, byte size of instruction memory; legal fetch pc range 0..IMEM_BYTES-4.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low; reset==0 clears all state immediately.
REQ-005 imem_pc  out  32  byte address to instruction memory, combinational copy of internal pc register.
REQ-006 imem_instr  in  32  instruction word returned combinationally by memory for imem_pc (little-endian).
REQ-007 branch_taken  in  1  redirect request from execute stage, single-cycle pulse.
REQ-008 branch_target  in  32  redirect byte address, valid when branch_taken==1.
REQ-009 id_ready  in  1  decode stage can accept the IF/ID entry this cycle.
REQ-010 id_valid  out  1  IF/ID entry holds a valid instruction.
REQ-011 id_instr  out  32  registered instruction word.
REQ-012 id_pc  out  32  byte address id_instr was fetched from.
REQ-013 trap  out  1  sticky fault flag: misaligned or out-of-range fetch address.

Function
REQ-014 State machine SHALL have three states: IDLE, RUN, TRAP; encoding free.
REQ-015 IDLE SHALL last exactly one cycle after reset deasserts (memory contents settle), issue no capture, then go to RUN; branch_taken ignored in IDLE.
REQ-016 In RUN, slot_free = !id_valid || id_ready; handshake completes when id_valid && id_ready.
REQ-017 In RUN, branch_taken==1 SHALL take priority: id_valid<=0 (flush, regardless of id_ready), pc<=branch_target; no capture that cycle.
REQ-018 A branch_target with bits[1:0]!=0 or > IMEM_BYTES-4 SHALL not be loaded into pc; state<=TRAP, trap<=1, id_valid<=0.
REQ-019 In RUN, no branch, pc legal, slot_free: id_instr<=imem_instr, id_pc<=pc, id_valid<=1, pc<=pc+4 (32-bit modulo add).
REQ-020 In RUN, no branch, !slot_free (stall): pc, id_valid, id_instr, id_pc SHALL hold unchanged.
REQ-021 In RUN, no branch, pc > IMEM_BYTES-4 or pc[1:0]!=0: no capture, state<=TRAP, trap<=1; existing valid entry retained until handshake.
REQ-022 Throughput SHALL be one instruction per cycle with id_ready held high; fetch-to-id_valid latency one cycle.
REQ-023 In TRAP: no fetch, pc frozen, branch_taken ignored, id_valid cleared on handshake, trap held 1 until reset.
REQ-024 imem_pc SHALL equal pc in every state, including TRAP.

Reset
REQ-025 On reset==0: pc=RESET_PC, state=IDLE, id_valid=0, id_instr=0, id_pc=0, trap=0, asynchronously.
REQ-026 Reset asserted mid-stall or mid-branch SHALL discard the pending entry and redirect; no partial update survives.
REQ-027 First capture SHALL occur on the second rising edge after reset deasserts (after IDLE).

Verification
REQ-028 Reset release, id_ready=1, memory words W0..W5 at 0..20 -> id_valid rises cycle 2; id_pc 0,4,8,...,20 with matching id_instr, one per cycle.
REQ-029 id_ready=0 for 3 cycles while id_valid=1, id_pc=8 -> id_pc/id_instr/imem_pc (12) hold; resume delivers id_pc=12 next.
REQ-030 branch_taken=1, branch_target=16 with id_valid=1, id_ready=0 -> next cycle id_valid=0, imem_pc=16; following cycle id_pc=16.
REQ-031 branch_target=6 (misaligned) or 256 (IMEM_BYTES=256) -> trap=1 next cycle, id_valid=0, imem_pc unchanged, later branches ignored.
REQ-032 Sequential fetch reaching pc=256 -> entry for 252 delivered, then trap=1 and no further id_valid.
REQ-033 Assert reset==0 mid-stream at a non-edge time -> outputs zero immediately, imem_pc=RESET_PC; refetch from RESET_PC after IDLE.
